cr_axi4s_pkt_arb: RTL and testbench
===================================

# cr_axi4s_pkt_arb

Packet-level round-robin arbiter that merges N_PORTS AXI4-stream slave FIFO read sides onto one registered AXI4-stream master output. It sits downstream of a bank of cr_axi4s2_slv instances, consuming each instance's first-word-fall-through `rdata`/`empty`/`rd` interface. Grant is held for a whole packet (through the beat with `tlast`), so packets from different ports never interleave. Output is a one-beat register honouring downstream `tready`.

## Interface
- `N_PORTS`, 4: number of requesting slave FIFOs, 2..8.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `slv_out` input N_PORTS x axi4s_dp_bus_t: FWFT head entry of each FIFO; valid only while the matching `slv_empty` bit is 0.
- `slv_empty` input N_PORTS: FIFO empty flags.
- `slv_rd` output N_PORTS: one-hot read/pop strobe.
- `port_en` input N_PORTS: per-port arbitration enable, sampled only at arbitration.
- `axi4s_ob_out` output axi4s_dp_bus_t: registered master beat; `tvalid` is the valid bit.
- `axi4s_ob_in` input axi4s_dp_rdy_t: downstream `tready`.
- `arb_busy` output 1: 1 while state is XFER.
- `arb_grant_id` output $clog2(N_PORTS): currently or last granted port.

## Operation
- State machine: IDLE, XFER.
- IDLE:
  - Candidate set is `port_en & ~slv_empty`.
  - If the set is non-empty, grant the first candidate searching upward (with wrap) from `last_grant+1`.
  - Register the grant in `grant`/`last_grant` and go to XFER.
  - If the set is empty, stay in IDLE.
  - No read is issued in IDLE.
- XFER:
  - `load = ~slv_empty[grant] & (~ob_valid | tready)`.
  - `slv_rd[grant] = load`; all other `slv_rd` bits are 0.
  - On `load`, the output register captures `slv_out[grant]` with `tvalid` forced to 1.
  - If the loaded beat has `tlast=1`, go to IDLE next cycle.
  - An empty granted FIFO mid-packet holds XFER with no read. There is no timeout.
- Output register:
  - Without `load`, `tready=1` clears `tvalid` (other fields hold).
  - With `tready=0`, the whole beat holds stable.
  - Simultaneous `tready` and `load` replaces the beat, giving full throughput within a packet.
- `port_en` changes during XFER have no effect until the next IDLE. Disabling the granted port does not truncate its packet.
- `slv_rd` is combinational from state, `grant`, `slv_empty`, `tvalid` and `tready`. It is never asserted to an empty FIFO and never more than one bit.
- Reset values:
  - State IDLE.
  - `last_grant = N_PORTS-1`, so port 0 is first after reset.
  - `grant = 0` and `arb_grant_id = 0`.
  - `axi4s_ob_out` all zeros, including `tvalid = 0`.
  - `slv_rd = 0`, `arb_busy = 0`.
- Reset asserted mid-packet discards the output beat and the grant immediately (asynchronously). The FIFOs are not flushed by this block.

## Timing
- First-beat latency: port goes non-empty in IDLE at cycle N → grant registered and `arb_busy=1` at N+1 → `slv_rd` pulses at N+1 (register free) → `tvalid=1` at N+2.
- Inter-packet gap: beat with `tlast` loaded at cycle M → IDLE at M+1 (arbitrate) → next packet's first `slv_rd` at M+2. This gives exactly one read-bubble cycle per packet boundary.
- Single-beat packets: at most one packet per 2 cycles.
- Sustained within a packet: 1 beat/cycle while `tready=1` and the FIFO is non-empty.
- Backpressure: `tready=0` with `tvalid=1` stalls reads the same cycle. `slv_rd` is 0 that cycle.

## Test plan
- Reset: after `rst_n` release with all FIFOs empty → `tvalid=0`, `slv_rd=0`, `arb_busy=0` for 20 cycles.
- Round-robin fairness: ports 0..3 each hold three 4-beat packets, `tready=1` → output port order 0,1,2,3,0,1,2,3,…; each packet contiguous; 5 cycles per packet.
- Backpressure: port 1 holds a 6-beat packet, `tready` toggles 1/0 every cycle → all 6 beats in order, no drop or duplicate, beat stable while `tready=0`, exactly 6 `slv_rd` pulses.
- Mid-packet underflow plus competitor: port 2 holds 2 beats of a 5-beat packet, port 0 holds a full packet, remaining 3 beats of port 2 arrive 10 cycles later → port 0 not granted until port 2's `tlast` is delivered.
- Enable mask: `port_en=4'b1011` with all ports loaded → port 2 never read. Setting `port_en[2]=1` during port 1's packet → port 2 is granted at the next IDLE after port 1.
- Reset mid-packet: assert `rst_n=0` during beat 3 of an 8-beat packet → `tvalid=0` immediately, state IDLE, next grant goes to port 0.

Source files
------------

// File: rtl/cr_axi4s_pkt_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cr_axi4s_pkt_arb                                                     |
// | Packet-level round-robin arbiter merging N_PORTS FWFT FIFO read      |
// | sides onto one registered AXI4-stream master beat.                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+

package cr_axi4s_pkt_arb_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tkeep;
    logic [31:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

module cr_axi4s_pkt_arb
  import cr_axi4s_pkt_arb_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  axi4s_dp_bus_t [N_PORTS-1:0]    slv_out,
  input  logic [N_PORTS-1:0]             slv_empty,
  output logic [N_PORTS-1:0]             slv_rd,
  input  logic [N_PORTS-1:0]             port_en,
  output axi4s_dp_bus_t                  axi4s_ob_out,
  input  axi4s_dp_rdy_t                  axi4s_ob_in,
  output logic                           arb_busy,
  output logic [$clog2(N_PORTS)-1:0]     arb_grant_id
);

  localparam int GW = $clog2(N_PORTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  axi4s_dp_bus_t   ob_q, ob_d;

  logic [N_PORTS-1:0] cand;
  logic [GW-1:0]      idx;
  logic               found;
  logic               load;

  // Next-state, round-robin pick and output-register update
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ob_d    = ob_q;
    slv_rd  = '0;
    load    = 1'b0;
    found   = 1'b0;
    idx     = '0;
    cand    = port_en & ~slv_empty;

    // A consumed beat retires; fields are kept, only valid drops
    if (axi4s_ob_in.tready) begin
      ob_d.tvalid = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Search upward from the port after the last winner, with wrap
        for (int i = 1; i <= N_PORTS; i++) begin
          idx = GW'((int'(last_q) + i) % N_PORTS);
          if (!found && cand[idx]) begin
            found   = 1'b1;
            grant_d = idx;
          end
        end
        if (found) begin
          last_d  = grant_d;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Pop only when data exists and the output slot is free or draining
        load = ~slv_empty[grant_q] & (~ob_q.tvalid | axi4s_ob_in.tready);
        if (load) begin
          slv_rd[grant_q] = 1'b1;
          ob_d            = slv_out[grant_q];
          ob_d.tvalid     = 1'b1;
          if (slv_out[grant_q].tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and output beat registers; reset drops any beat in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      ob_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ob_q    <= ob_d;
    end
  end

  assign axi4s_ob_out = ob_q;
  assign arb_busy     = (state_q == ST_XFER);
  assign arb_grant_id = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_axi4s_pkt_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cr_axi4s_pkt_arb                                                  |
// | Directed self-checking bench for the packet round-robin arbiter.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+

module tb_cr_axi4s_pkt_arb;
  import cr_axi4s_pkt_arb_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  axi4s_dp_bus_t [N-1:0] slv_out;
  logic [N-1:0]         slv_empty;
  logic [N-1:0]         slv_rd;
  logic [N-1:0]         port_en;
  axi4s_dp_bus_t        ob_out;
  axi4s_dp_rdy_t        ob_in;
  logic                 arb_busy;
  logic [1:0]           arb_grant_id;

  cr_axi4s_pkt_arb #(.N_PORTS(N)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slv_out      (slv_out),
    .slv_empty    (slv_empty),
    .slv_rd       (slv_rd),
    .port_en      (port_en),
    .axi4s_ob_out (ob_out),
    .axi4s_ob_in  (ob_in),
    .arb_busy     (arb_busy),
    .arb_grant_id (arb_grant_id)
  );

  always #5 clk = ~clk;

  // FIFO contents per port and expected output stream, {tlast, tdata}
  logic [32:0]   fq [N][$];
  logic [32:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            hs_cnt = 0;
  int            first_hs_cyc = 0;
  int            last_hs_cyc = 0;
  int            rd_cnt [N];
  logic          toggle_rdy = 1'b0;
  logic          prev_stall = 1'b0;
  axi4s_dp_bus_t prev_beat;
  logic [32:0]   tmp;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] mk(input int port, input int pkt, input int beat, input int len);
    return {(beat == len - 1), 8'(port), 8'(pkt), 8'(beat), 8'hA5};
  endfunction

  task automatic update_inputs();
    logic [32:0] h;
    for (int p = 0; p < N; p++) begin
      slv_empty[p] = (fq[p].size() == 0);
      if (fq[p].size() == 0) begin
        slv_out[p] = '0;
      end else begin
        h                  = fq[p][0];
        slv_out[p].tvalid  = 1'b1;
        slv_out[p].tlast   = h[32];
        slv_out[p].tkeep   = 4'hF;
        slv_out[p].tdata   = h[31:0];
      end
    end
  endtask

  task automatic put_pkt(input int port, input int pkt, input int first, input int lastb, input int len);
    for (int b = first; b <= lastb; b++) fq[port].push_back(mk(port, pkt, b, len));
    update_inputs();
  endtask

  task automatic exp_pkt(input int port, input int pkt, input int first, input int lastb, input int len);
    for (int b = first; b <= lastb; b++) exp_q.push_back(mk(port, pkt, b, len));
  endtask

  // One clock: sample at negedge, then model FIFO pops and score handshakes
  task automatic tick();
    logic [N-1:0]  rd;
    logic          hs, stall, oh, hit;
    axi4s_dp_bus_t beat;
    logic [32:0]   got;
    @(negedge clk);
    rd    = slv_rd;
    beat  = ob_out;
    hs    = beat.tvalid & ob_in.tready;
    stall = beat.tvalid & ~ob_in.tready;
    oh    = $onehot(rd);
    hit   = |(rd & slv_empty);
    if (prev_stall) check("stall_hold", beat, prev_beat);
    if (stall) check("stall_rd", rd, 0);
    if (rd != 0) check("rd_legal", {oh, hit}, 2'b10);
    prev_stall = stall;
    prev_beat  = beat;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (rd[p]) begin
        rd_cnt[p]++;
        if (fq[p].size() != 0) void'(fq[p].pop_front());
      end
    end
    update_inputs();
    if (hs) begin
      got = {beat.tlast, beat.tdata};
      if (hs_cnt == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
      if (exp_q.size() == 0) check("unexp_beat", got, 0);
      else check("beat", got, exp_q.pop_front());
    end
    if (toggle_rdy) ob_in.tready = ~ob_in.tready;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    port_en      = 4'hF;
    ob_in.tready = 1'b1;
    slv_out      = '0;
    slv_empty    = '1;
    for (int p = 0; p < N; p++) rd_cnt[p] = 0;
    update_inputs();

    // Reset and idle with empty FIFOs
    repeat (3) tick();
    check("rst_out", ob_out, 0);
    check("rst_gid", arb_grant_id, 0);
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      check("idle", {ob_out.tvalid, slv_rd, arb_busy}, 0);
    end

    // Round-robin: three 4-beat packets on every port
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < N; p++) begin
        put_pkt(p, k, 0, 3, 4);
        exp_pkt(p, k, 0, 3, 4);
      end
    end
    hs_cnt = 0;
    #1;
    check("arb_idle_rd", {arb_busy, slv_rd}, 0);
    tick();
    check("lat_grant", {arb_busy, arb_grant_id, slv_rd}, {1'b1, 2'd0, 4'b0001});
    tick();
    check("lat_valid", {ob_out.tvalid, ob_out.tdata}, {1'b1, 32'h0000_00A5});
    drain(400);
    check("rr_span", last_hs_cyc - first_hs_cyc, 58);

    // Backpressure: tready toggling on a 6-beat packet from port 1
    for (int p = 0; p < N; p++) rd_cnt[p] = 0;
    put_pkt(1, 9, 0, 5, 6);
    exp_pkt(1, 9, 0, 5, 6);
    toggle_rdy = 1'b1;
    drain(100);
    toggle_rdy   = 1'b0;
    ob_in.tready = 1'b1;
    repeat (3) tick();
    check("bp_rd1", rd_cnt[1], 6);
    check("bp_rd_other", rd_cnt[0] + rd_cnt[2] + rd_cnt[3], 0);

    // Mid-packet underflow on port 2 with port 0 waiting
    put_pkt(2, 3, 0, 1, 5);
    put_pkt(0, 4, 0, 2, 3);
    exp_pkt(2, 3, 0, 4, 5);
    exp_pkt(0, 4, 0, 2, 3);
    repeat (10) tick();
    check("uf_hold", {arb_busy, arb_grant_id, slv_rd}, {1'b1, 2'd2, 4'b0000});
    check("uf_p0_wait", fq[0].size(), 3);
    put_pkt(2, 3, 2, 4, 5);
    drain(100);

    // Enable mask: port 2 disabled, then enabled during port 1's packet
    port_en = 4'b1011;
    for (int p = 0; p < N; p++) begin
      rd_cnt[p] = 0;
      put_pkt(p, 7, 0, 2, 3);
    end
    exp_pkt(1, 7, 0, 2, 3);
    exp_pkt(3, 7, 0, 2, 3);
    exp_pkt(0, 7, 0, 2, 3);
    drain(100);
    repeat (4) tick();
    check("en_p2_rd", rd_cnt[2], 0);
    check("en_p2_left", fq[2].size(), 3);
    put_pkt(1, 8, 0, 2, 3);
    tick();
    check("en_g1", {arb_busy, arb_grant_id}, {1'b1, 2'd1});
    port_en = 4'hF;
    exp_pkt(1, 8, 0, 2, 3);
    exp_pkt(2, 7, 0, 2, 3);
    drain(100);

    // Reset during beat 3 of an 8-beat packet on port 3
    put_pkt(3, 5, 0, 7, 8);
    put_pkt(0, 6, 0, 1, 2);
    exp_pkt(3, 5, 0, 1, 8);
    drain(50);
    tmp = mk(3, 5, 2, 8);
    check("pre_rst_beat", {ob_out.tvalid, ob_out.tlast, ob_out.tdata}, {1'b1, tmp});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {ob_out.tvalid, arb_busy, arb_grant_id, slv_rd}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    exp_pkt(0, 6, 0, 1, 2);
    exp_pkt(3, 5, 3, 7, 8);
    tick();
    check("rst_regrant", {arb_busy, arb_grant_id}, {1'b1, 2'd0});
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
